// File: rtl/universal_register_pkg.sv
// Shared types for the universal register: operation select encoding.
package universal_register_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      ROL  = 3'd4,
      ROR  = 3'd5,
      INC  = 3'd6,
      DEC  = 3'd7
   } mode_t;

endpackage

// File: rtl/universal_register_if.sv
// Control/data bundle of the universal register; clock and reset stay plain ports.
interface universal_register_if #(
   parameter int WIDTH = 8
);
   import universal_register_pkg::*;

   logic             clear;
   logic             enable;
   mode_t            mode;
   logic [WIDTH-1:0] d;
   logic             serial_in;
   logic [WIDTH-1:0] q;
   logic             serial_out;
   logic             carry;
   logic             zero;

   modport master (
      output clear, enable, mode, d, serial_in,
      input  q, serial_out, carry, zero
   );

   modport slave (
      input  clear, enable, mode, d, serial_in,
      output q, serial_out, carry, zero
   );
endinterface

// File: rtl/universal_register.sv
// Universal register (load/shift/rotate/inc/dec), one-cycle latency, no backpressure.
// enable=0 holds all state; clear beats enable; async active-low reset beats everything.
module universal_register
   import universal_register_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   universal_register_if.slave bus
);

   logic [WIDTH-1:0] r_q;
   logic             r_serial_out;
   logic             r_carry;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_serial_out_nxt;
   logic             w_carry_nxt;
   logic [WIDTH:0]   w_sum;

   always_comb begin
      w_q_nxt          = r_q;
      w_serial_out_nxt = r_serial_out;
      w_carry_nxt      = r_carry;
      w_sum            = '0;
      case (bus.mode)
         HOLD: ;
         LOAD: w_q_nxt = bus.d;
         SHL: begin
            w_q_nxt          = {r_q[WIDTH-2:0], bus.serial_in};
            w_serial_out_nxt = r_q[WIDTH-1];
         end
         SHR: begin
            w_q_nxt          = {bus.serial_in, r_q[WIDTH-1:1]};
            w_serial_out_nxt = r_q[0];
         end
         ROL: begin
            w_q_nxt          = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_serial_out_nxt = r_q[WIDTH-1];
         end
         ROR: begin
            w_q_nxt          = {r_q[0], r_q[WIDTH-1:1]};
            w_serial_out_nxt = r_q[0];
         end
         // Extra MSB of the WIDTH+1 result is the carry (INC) or borrow (DEC).
         INC: begin
            w_sum       = {1'b0, r_q} + (WIDTH+1)'(1);
            w_q_nxt     = w_sum[WIDTH-1:0];
            w_carry_nxt = w_sum[WIDTH];
         end
         DEC: begin
            w_sum       = {1'b0, r_q} - (WIDTH+1)'(1);
            w_q_nxt     = w_sum[WIDTH-1:0];
            w_carry_nxt = w_sum[WIDTH];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_q          <= RESET_VALUE;
         r_serial_out <= 1'b0;
         r_carry      <= 1'b0;
      end else if (bus.clear) begin
         r_q          <= RESET_VALUE;
         r_serial_out <= 1'b0;
         r_carry      <= 1'b0;
      end else if (bus.enable) begin
         r_q          <= w_q_nxt;
         r_serial_out <= w_serial_out_nxt;
         r_carry      <= w_carry_nxt;
      end
   end

   assign bus.q          = r_q;
   assign bus.serial_out = r_serial_out;
   assign bus.carry      = r_carry;
   assign bus.zero       = (r_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed, table-driven bench for universal_register at WIDTH=4.
module tb_universal_register;
   import universal_register_pkg::*;

   localparam int W = 4;

   typedef struct {
      logic         clr;
      logic         en;
      mode_t        mode;
      logic [W-1:0] d;
      logic         sin;
      logic [W-1:0] q;
      logic         so;
      logic         c;
      logic         z;
   } vec_t;

   localparam int NV = 30;

   logic clock;
   logic reset;
   int   n_chk;
   int   n_pass;
   vec_t vecs [NV];

   universal_register_if #(.WIDTH(W)) bus ();

   universal_register #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(logic clr, logic en, mode_t mode, logic [W-1:0] d, logic sin,
                               logic [W-1:0] q, logic so, logic c, logic z);
      vec_t v;
      v.clr = clr; v.en = en; v.mode = mode; v.d = d; v.sin = sin;
      v.q = q; v.so = so; v.c = c; v.z = z;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk_all(string tag, logic [W-1:0] q, logic so, logic c, logic z);
      chk({tag, " q"},          32'(bus.q),          32'(q));
      chk({tag, " serial_out"}, 32'(bus.serial_out), 32'(so));
      chk({tag, " carry"},      32'(bus.carry),      32'(c));
      chk({tag, " zero"},       32'(bus.zero),       32'(z));
   endtask

   task automatic drive(logic clr, logic en, mode_t mode, logic [W-1:0] d, logic sin);
      bus.clear     = clr;
      bus.enable    = en;
      bus.mode      = mode;
      bus.d         = d;
      bus.serial_in = sin;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;

      //              clr  en  mode  d        sin   q        so   c    z
      vecs[0]  = mk(1'b0,1'b1,LOAD,4'b1011,1'b0, 4'b1011,1'b0,1'b0,1'b0);
      vecs[1]  = mk(1'b0,1'b1,SHL, 4'b0000,1'b0, 4'b0110,1'b1,1'b0,1'b0);
      vecs[2]  = mk(1'b0,1'b1,SHR, 4'b0000,1'b1, 4'b1011,1'b0,1'b0,1'b0);
      vecs[3]  = mk(1'b0,1'b1,SHR, 4'b0000,1'b0, 4'b0101,1'b1,1'b0,1'b0);
      vecs[4]  = mk(1'b0,1'b1,SHR, 4'b0000,1'b0, 4'b0010,1'b1,1'b0,1'b0);
      vecs[5]  = mk(1'b0,1'b1,SHR, 4'b0000,1'b0, 4'b0001,1'b0,1'b0,1'b0);
      vecs[6]  = mk(1'b0,1'b1,SHR, 4'b0000,1'b0, 4'b0000,1'b1,1'b0,1'b1);
      vecs[7]  = mk(1'b0,1'b1,LOAD,4'b1001,1'b0, 4'b1001,1'b1,1'b0,1'b0);
      vecs[8]  = mk(1'b0,1'b1,ROL, 4'b0000,1'b0, 4'b0011,1'b1,1'b0,1'b0);
      vecs[9]  = mk(1'b0,1'b1,ROR, 4'b0000,1'b1, 4'b1001,1'b1,1'b0,1'b0);
      vecs[10] = mk(1'b0,1'b1,ROR, 4'b0000,1'b0, 4'b1100,1'b1,1'b0,1'b0);
      vecs[11] = mk(1'b0,1'b1,ROL, 4'b0000,1'b1, 4'b1001,1'b1,1'b0,1'b0);
      vecs[12] = mk(1'b0,1'b1,LOAD,4'b1110,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[13] = mk(1'b0,1'b1,INC, 4'b0000,1'b0, 4'b1111,1'b1,1'b0,1'b0);
      vecs[14] = mk(1'b0,1'b1,INC, 4'b0000,1'b0, 4'b0000,1'b1,1'b1,1'b1);
      vecs[15] = mk(1'b0,1'b1,DEC, 4'b0000,1'b0, 4'b1111,1'b1,1'b1,1'b0);
      vecs[16] = mk(1'b0,1'b1,DEC, 4'b0000,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[17] = mk(1'b0,1'b1,HOLD,4'b0101,1'b1, 4'b1110,1'b1,1'b0,1'b0);
      vecs[18] = mk(1'b0,1'b0,LOAD,4'b0101,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[19] = mk(1'b0,1'b0,LOAD,4'b0101,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[20] = mk(1'b0,1'b0,LOAD,4'b0101,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[21] = mk(1'b0,1'b0,SHR, 4'b0000,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[22] = mk(1'b0,1'b1,LOAD,4'b0000,1'b0, 4'b0000,1'b1,1'b0,1'b1);
      vecs[23] = mk(1'b0,1'b1,DEC, 4'b0000,1'b0, 4'b1111,1'b1,1'b1,1'b0);
      vecs[24] = mk(1'b0,1'b0,INC, 4'b0000,1'b0, 4'b1111,1'b1,1'b1,1'b0);
      vecs[25] = mk(1'b1,1'b1,INC, 4'b0000,1'b0, 4'b0000,1'b0,1'b0,1'b1);
      vecs[26] = mk(1'b0,1'b1,LOAD,4'b0111,1'b0, 4'b0111,1'b0,1'b0,1'b0);
      vecs[27] = mk(1'b0,1'b1,SHL, 4'b0000,1'b1, 4'b1111,1'b0,1'b0,1'b0);
      vecs[28] = mk(1'b0,1'b1,SHL, 4'b0000,1'b0, 4'b1110,1'b1,1'b0,1'b0);
      vecs[29] = mk(1'b0,1'b1,LOAD,4'b0111,1'b1, 4'b0111,1'b1,1'b0,1'b0);

      // Asynchronous reset before any clock edge.
      drive(1'b0, 1'b0, HOLD, '0, 1'b0);
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 chk_all("async reset", 4'b0000, 1'b0, 1'b0, 1'b1);

      // Hold reset across an edge with a live LOAD request; it must be ignored.
      drive(1'b0, 1'b1, LOAD, 4'b1010, 1'b0);
      @(posedge clock); #2;
      chk_all("reset held", 4'b0000, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
         @(posedge clock); #2;
         chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].so, vecs[i].c, vecs[i].z);
      end

      // Reset mid INC sequence at q=0111: immediate, and the INC on the next edge is lost.
      drive(1'b0, 1'b1, INC, 4'b0000, 1'b0);
      #1 reset = 1'b0;
      #1 chk_all("mid reset", 4'b0000, 1'b0, 1'b0, 1'b1);
      @(posedge clock); #2;
      chk_all("inc during reset", 4'b0000, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      @(posedge clock); #2;
      chk_all("inc after release", 4'b0001, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor to the basic load/clear register.
- Adds width-generic operating modes: parallel load, logical shifts with serial in/out, rotates, and increment/decrement with carry/borrow flag.
- Used as the general-purpose accumulator/shift element in the logic-design exercise datapaths.
- Single clock domain; all state updates on the rising clock edge.

Parameters:
- WIDTH, 8, data width in bits (must be at least 2).
- RESET_VALUE, '0, value q takes on reset and on clear.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset: asserted when 0, released when 1.
- clear  input  1  synchronous clear, highest synchronous priority.
- enable  input  1  when 0, all state holds regardless of mode.
- mode  input  3  operation select, type mode_t.
- d  input  WIDTH  parallel load data.
- serial_in  input  1  fill bit for SHL/SHR.
- q  output  WIDTH  stored value.
- serial_out  output  1  last bit shifted or rotated out (registered).
- carry  output  1  carry/borrow of last INC/DEC (registered).
- zero  output  1  combinational flag, 1 iff q == 0.

Behaviour:
- Reset (reset==0, asynchronous): q=RESET_VALUE, serial_out=0, carry=0. All outputs take these values immediately, without waiting for a clock edge.
- Reset release is synchronous to clock. The first operation executes on the first rising edge after reset==1.
- Priority at each rising edge: reset > clear > (enable & mode) > hold.
- clear==1: q=RESET_VALUE, serial_out=0, carry=0. enable and mode are ignored.
- enable==0 and clear==0: q, serial_out and carry all hold.
- Latency: one cycle. The result is visible on q right after the edge that sampled the inputs.
- Modes when enable==1 (mode_t encoding):
  - 0 HOLD: nothing changes.
  - 1 LOAD: q=d. serial_out and carry hold.
  - 2 SHL: q={q[W-2:0],serial_in}; serial_out=q[W-1]; carry holds.
  - 3 SHR: q={serial_in,q[W-1:1]}; serial_out=q[0]; carry holds.
  - 4 ROL: q={q[W-2:0],q[W-1]}; serial_out=q[W-1]; carry holds. serial_in is ignored.
  - 5 ROR: q={q[0],q[W-1:1]}; serial_out=q[0]; carry holds.
  - 6 INC: q=q+1 modulo 2^WIDTH; carry=1 iff old q was all ones, else 0; serial_out holds.
  - 7 DEC: q=q-1 modulo 2^WIDTH; carry(borrow)=1 iff old q was 0, else 0; serial_out holds.
- Arithmetic is computed at WIDTH+1 bits. The MSB is the carry/borrow; the result is truncated to WIDTH bits.
- Wrap-around: INC from all ones gives 0 with carry=1. DEC from 0 gives all ones with carry=1.
- Mode changes take effect on the next edge. There is no pipelining or state carried between modes except the flags described above.
- Reset asserted mid-sequence overrides immediately. Any operation on the same edge is lost.
- zero is derived from q only, so it is valid one cycle after the operation and during reset.

Decomposition:
- universal_register_pkg holds:
  - typedef enum logic[2:0] mode_t {HOLD, LOAD, SHL, SHR, ROL, ROR, INC, DEC};
  - the mode encoding constants used by benches.
- No sub-module. Structure is one always_comb next-state/flag computation (case on mode) plus one always_ff with async active-low reset.

Test Plan:
- Reset and clear (WIDTH=4):
  - reset=0 -> q=0000, serial_out=0, carry=0, zero=1 without a clock edge.
  - Release, then LOAD d=1011 -> q=1011, zero=0.
- Shifts:
  - q=1011, SHL serial_in=0 -> q=0110, serial_out=1.
  - Then SHR serial_in=1 -> q=1011, serial_out=0.
  - Four SHR with serial_in=0 -> q=0000, zero=1.
- Rotates:
  - q=1001, ROL -> q=0011, serial_out=1.
  - ROR twice from 0011 -> 1001 then 1100, serial_out=1 then 1.
  - serial_in toggled throughout has no effect.
- Counter wrap:
  - q=1110, INC, INC -> 1111 (carry=0) then 0000 (carry=1, zero=1).
  - DEC -> 1111, carry=1.
  - DEC -> 1110, carry=0.
- Priority and hold:
  - enable=0 with mode=LOAD, d=0101 -> q unchanged for 3 cycles.
  - clear=1 with enable=1, mode=INC -> q=0000, carry=0.
- Async reset mid-operation:
  - reset=0 asserted between edges during an INC sequence at q=0111 -> q=0000 immediately.
  - The INC on the next edge while reset=0 is lost.
  - After release, INC -> 0001.
